// File: rtl/texture_palette_bank.sv
// texture_palette_bank
//   Runtime-loadable multi-bank colour palette. Each bank holds one texture's
//   palette of 2**INDEX_W entries packed {R,G,B} (R in the MSBs). Banks are
//   filled through a streaming write port; the pixel pipeline performs one
//   (bank, index, shade) lookup per cycle with a fixed 2-cycle latency.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   load_start, load_bank   one-cycle pulse that starts filling load_bank
//   wr_valid, wr_data       palette entry stream, accepted on wr_valid && wr_ready
//   wr_ready, load_busy     high while a bank is being filled
//   load_done               one-cycle pulse after the last entry is written
//   rd_valid, rd_bank,      lookup request (no backpressure)
//   rd_index, rd_shade
//   out_valid, out_red,     shaded colour and transparency flag, rd_valid
//   out_green, out_blue,    delayed by two cycles; colour holds while
//   out_transparent         out_valid is low
module texture_palette_bank #(
   parameter int unsigned NUM_BANKS    = 8,
   parameter int unsigned INDEX_W      = 8,
   parameter int unsigned CHAN_W       = 4,
   parameter int unsigned SHADE_W      = 4,
   parameter bit          TRANSP_EN    = 1'b1,
   parameter int unsigned TRANSP_INDEX = 0,
   parameter int unsigned BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic [BANK_W-1:0]     load_bank,
   input  logic                  wr_valid,
   input  logic [3*CHAN_W-1:0]   wr_data,
   output logic                  wr_ready,
   output logic                  load_busy,
   output logic                  load_done,
   input  logic                  rd_valid,
   input  logic [BANK_W-1:0]     rd_bank,
   input  logic [INDEX_W-1:0]    rd_index,
   input  logic [SHADE_W-1:0]    rd_shade,
   output logic                  out_valid,
   output logic [CHAN_W-1:0]     out_red,
   output logic [CHAN_W-1:0]     out_green,
   output logic [CHAN_W-1:0]     out_blue,
   output logic                  out_transparent
);

   localparam int unsigned ENTRY_W = 3 * CHAN_W;
   localparam int unsigned ADDR_W  = BANK_W + INDEX_W;
   localparam int unsigned DEPTH   = 2 ** ADDR_W;
   localparam int unsigned PROD_W  = CHAN_W + SHADE_W + 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_LOAD = 1'b1;

   // ---------------------------------------------------------------------
   // Load FSM
   // ---------------------------------------------------------------------
   logic [0:0]         state_q, state_d;
   logic [INDEX_W-1:0] addr_q, addr_d;
   logic [BANK_W-1:0]  bank_q, bank_d;
   logic               done_q, done_d;
   logic               beat;

   assign beat = (state_q == ST_LOAD) && wr_valid;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      bank_d  = bank_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_start) begin
               state_d = ST_LOAD;
               bank_d  = load_bank;
               addr_d  = '0;
            end
         end
         ST_LOAD: begin
            // load_start is deliberately ignored here: no restart mid-fill.
            if (beat) begin
               if (addr_q == {INDEX_W{1'b1}}) begin
                  state_d = ST_IDLE;
                  addr_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         bank_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         bank_q  <= bank_d;
         done_q  <= done_d;
      end
   end

   assign wr_ready  = (state_q == ST_LOAD);
   assign load_busy = (state_q == ST_LOAD);
   assign load_done = done_q;

   // ---------------------------------------------------------------------
   // Palette RAM: banks are concatenated as {bank, index}. An out-of-range
   // bank simply aliases modulo 2**BANK_W. The read register samples the
   // array before this edge's write lands, giving read-before-write.
   // ---------------------------------------------------------------------
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [ENTRY_W-1:0] rd_entry_q;

   always_ff @(posedge clk) begin
      if (beat) begin
         mem[{bank_q, addr_q}] <= wr_data;
      end
      rd_entry_q <= mem[{rd_bank, rd_index}];
   end

   // ---------------------------------------------------------------------
   // Stage 1: side-band registered alongside the RAM read
   // ---------------------------------------------------------------------
   logic               v1_q;
   logic [SHADE_W-1:0] shade1_q;
   logic               transp1_q;
   logic               transp_hit;

   assign transp_hit = TRANSP_EN && (rd_index == INDEX_W'(TRANSP_INDEX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q      <= 1'b0;
         shade1_q  <= '0;
         transp1_q <= 1'b0;
      end else begin
         v1_q      <= rd_valid;
         shade1_q  <= rd_shade;
         transp1_q <= transp_hit;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: shading and output registers
   // ---------------------------------------------------------------------
   // (c * (s + 1)) >> SHADE_W, so full-scale shade passes c unchanged.
   function automatic logic [CHAN_W-1:0] shade_chan(input logic [CHAN_W-1:0]  c,
                                                     input logic [SHADE_W-1:0] s);
      logic [SHADE_W:0]  s1;
      logic [PROD_W-1:0] prod;
      s1   = {1'b0, s} + {{SHADE_W{1'b0}}, 1'b1};
      prod = PROD_W'(c) * PROD_W'(s1);
      return CHAN_W'(prod >> SHADE_W);
   endfunction

   logic [CHAN_W-1:0] red_s, green_s, blue_s;

   assign red_s   = shade_chan(rd_entry_q[3*CHAN_W-1:2*CHAN_W], shade1_q);
   assign green_s = shade_chan(rd_entry_q[2*CHAN_W-1:CHAN_W], shade1_q);
   assign blue_s  = shade_chan(rd_entry_q[CHAN_W-1:0], shade1_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid       <= 1'b0;
         out_red         <= '0;
         out_green       <= '0;
         out_blue        <= '0;
         out_transparent <= 1'b0;
      end else begin
         out_valid <= v1_q;
         if (v1_q) begin
            out_red         <= red_s;
            out_green       <= green_s;
            out_blue        <= blue_s;
            out_transparent <= transp1_q;
         end
      end
   end

endmodule

// File: tb/tb_texture_palette_bank.sv
module tb_texture_palette_bank;

   localparam int NB = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_start = 1'b0;
   logic [2:0]  load_bank = '0;
   logic        wr_valid = 1'b0;
   logic [11:0] wr_data = '0;
   logic        wr_ready, load_busy, load_done;
   logic        rd_valid = 1'b0;
   logic [2:0]  rd_bank = '0;
   logic [7:0]  rd_index = '0;
   logic [3:0]  rd_shade = '0;
   logic        out_valid;
   logic [3:0]  out_red, out_green, out_blue;
   logic        out_transparent;

   // Second instance with transparency keying disabled
   logic        rd_valid2 = 1'b0;
   logic        n_wr_ready, n_load_busy, n_load_done, out_valid2, out_transparent2;
   logic [3:0]  n_red, n_green, n_blue;

   always #5 clk = ~clk;

   texture_palette_bank u_dut (
      .clk(clk), .rst_n(rst_n),
      .load_start(load_start), .load_bank(load_bank),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .load_busy(load_busy), .load_done(load_done),
      .rd_valid(rd_valid), .rd_bank(rd_bank), .rd_index(rd_index), .rd_shade(rd_shade),
      .out_valid(out_valid), .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
      .out_transparent(out_transparent)
   );

   texture_palette_bank #(
      .NUM_BANKS(2), .INDEX_W(2), .TRANSP_EN(1'b0)
   ) u_notr (
      .clk(clk), .rst_n(rst_n),
      .load_start(1'b0), .load_bank(1'b0),
      .wr_valid(1'b0), .wr_data(12'h000), .wr_ready(n_wr_ready),
      .load_busy(n_load_busy), .load_done(n_load_done),
      .rd_valid(rd_valid2), .rd_bank(1'b0), .rd_index(2'b00), .rd_shade(4'hF),
      .out_valid(out_valid2), .out_red(n_red), .out_green(n_green), .out_blue(n_blue),
      .out_transparent(out_transparent2)
   );

   typedef struct {
      logic [12:0] exp;
      int          due;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic [11:0] model [NB][256];

   always @(posedge clk) cyc <= cyc + 1;

   // Palette patterns: 0 generic, 1 bank-3 test, 2/3 bank-2 before/after,
   // 4 bank-1 interrupted, 5 bank-1 restart, 6 bank-4 with gaps
   function automatic logic [11:0] pat(int kind, int b, int i);
      logic [7:0] ix;
      ix = i[7:0];
      case (kind)
         0: return 12'((b * 849 + i * 151) ^ (i << 3));
         1: return {ix[3:0], ~ix[3:0], 4'h5};
         2: return (i == 16) ? 12'h123 : (i == 17) ? 12'hACD : (i == 0) ? 12'h9B7 : pat(0, b, i);
         3: return (i == 16) ? 12'h456 : pat(2, b, i);
         4: return ~pat(0, 1, i);
         5: return pat(0, 1, i) ^ 12'h3C3;
         default: return pat(0, 4, i) ^ 12'hA5A;
      endcase
   endfunction

   function automatic logic [3:0] shd(logic [3:0] c, logic [3:0] s);
      int p;
      p = int'(c) * (int'(s) + 1);
      return 4'(p >> 4);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      rd_valid   = 1'b0;
      wr_valid   = 1'b0;
      load_start = 1'b0;
      rd_valid2  = 1'b0;
   endtask

   task automatic push(logic [12:0] e);
      exp_t x;
      x.exp = e;
      x.due = cyc + 2;
      q.push_back(x);
   endtask

   task automatic req_hand(int b, int i, int s, logic [11:0] rgb, logic t);
      rd_valid = 1'b1;
      rd_bank  = 3'(b);
      rd_index = 8'(i);
      rd_shade = 4'(s);
      push({t, rgb});
   endtask

   task automatic req_model(int b, int i, int s);
      logic [11:0] e;
      logic [3:0]  sh;
      e  = model[b][i];
      sh = 4'(s);
      req_hand(b, i, s, {shd(e[11:8], sh), shd(e[7:4], sh), shd(e[3:0], sh)}, i == 0);
   endtask

   task automatic set_beat(int kind, int b, int i);
      wr_valid    = 1'b1;
      wr_data     = pat(kind, b, i);
      model[b][i] = wr_data;
   endtask

   task automatic start_load(int b);
      load_start = 1'b1;
      load_bank  = 3'(b);
      tick();
   endtask

   task automatic load_full(int kind, int b, bit coll, bit stray);
      bit ok;
      ok = 1'b1;
      start_load(b);
      for (int i = 0; i < 256; i++) begin
         if (stray && (i % 16 == 5)) begin
            if (!(wr_ready && load_busy && !load_done)) ok = 1'b0;
            tick();
         end
         if (!(wr_ready && load_busy && !load_done)) ok = 1'b0;
         if (coll && i == 16) req_hand(2, 16, 15, 12'h123, 1'b0);
         if (coll && i == 17) req_hand(2, 16, 15, 12'h456, 1'b0);
         if (stray && i == 40) begin
            load_start = 1'b1;
            load_bank  = 3'd6;
         end
         set_beat(kind, b, i);
         tick();
      end
      chk("load_ready_busy", 32'(ok), 1);
      chk("load_done_pulse", 32'(load_done), 1);
      chk("ready_drop", 32'(wr_ready), 0);
      chk("busy_drop", 32'(load_busy), 0);
      tick();
      chk("load_done_single", 32'(load_done), 0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t x;
      if (out_valid) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_out: out_valid with nothing expected at cycle %0d", cyc);
         end else begin
            x = q.pop_front();
            if ({out_transparent, out_red, out_green, out_blue} !== x.exp || x.due != cyc) begin
               n_bad++;
               $display("FAIL lookup: got t/rgb %0h at cycle %0d expected %0h at cycle %0d",
                        {out_transparent, out_red, out_green, out_blue}, cyc, x.exp, x.due);
            end
         end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         x = q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missing_out: no out_valid at cycle %0d expected %0h", cyc, x.exp);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_wr_ready", 32'(wr_ready), 0);
      chk("rst_load_busy", 32'(load_busy), 0);
      chk("rst_load_done", 32'(load_done), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_rgb", 32'({out_red, out_green, out_blue}), 0);
      chk("rst_out_transp", 32'(out_transparent), 0);
      rst_n = 1'b1;
      tick();

      for (int b = 0; b < NB; b++) load_full(0, b, 1'b0, 1'b0);

      // Bank 3 test pattern
      load_full(1, 3, 1'b0, 1'b0);
      req_hand(3, 8'h2A, 15, 12'hA55, 1'b0);
      tick();

      // Shading and transparency on bank 2
      load_full(2, 2, 1'b0, 1'b0);
      req_hand(2, 8'h11, 7, 12'h566, 1'b0);
      tick();
      req_hand(2, 8'h11, 0, 12'h000, 1'b0);
      tick();
      req_hand(2, 8'h11, 15, 12'hACD, 1'b0);
      tick();
      req_hand(2, 0, 15, 12'h9B7, 1'b1);
      tick();
      req_model(2, 1, 15);
      tick();

      // Transparency disabled: index 0 is not keyed
      rd_valid2 = 1'b1;
      tick();
      tick();
      chk("notr_valid", 32'(out_valid2), 1);
      chk("notr_transparent", 32'(out_transparent2), 0);

      // Same-cycle read/write collision on bank 2 index 0x10
      load_full(3, 2, 1'b1, 1'b0);
      tick();
      tick();

      // Reset in the middle of a load into bank 1
      start_load(1);
      for (int i = 0; i < 100; i++) begin
         set_beat(4, 1, i);
         tick();
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(load_busy), 0);
      chk("midrst_ready", 32'(wr_ready), 0);
      chk("midrst_out_rgb", 32'({out_red, out_green, out_blue}), 0);
      @(posedge clk);
      @(negedge clk);
      chk("midrst_no_done", 32'(load_done), 0);
      rst_n = 1'b1;
      tick();
      chk("midrst_no_done_after", 32'(load_done), 0);
      chk("midrst_idle", 32'(load_busy), 0);
      req_model(1, 0, 15);
      tick();
      req_model(1, 99, 15);
      tick();
      req_model(1, 100, 15);
      tick();
      req_model(1, 255, 15);
      tick();
      load_full(5, 1, 1'b0, 1'b0);
      req_model(1, 0, 15);
      tick();
      req_model(1, 255, 9);
      tick();

      // Gapped load with a stray load_start, then wr_valid while idle
      load_full(6, 4, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         wr_valid = 1'b1;
         wr_data  = 12'hFFF;
         tick();
         chk("idle_ignore", 32'({wr_ready, load_busy, load_done}), 0);
      end
      req_model(4, 0, 15);
      tick();
      for (int k = 0; k < 16; k++) begin
         req_model(k % 8, (k * 17 + 3) % 256, k);
         tick();
      end
      req_model(6, 40, 15);
      tick();

      for (int k = 0; k < 4; k++) tick();
      chk("queue_drained", 32'(q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/texture_palette_bank.md
Name: texture_palette_bank

Overview:
- Runtime-loadable, multi-bank colour palette for the texture renderer.
- Replaces per-texture constant palette ROMs: each bank holds one texture's palette. Banks are filled over a streaming write port at boot or on level change.
- Pixel pipeline issues (bank, index, shade) lookups every cycle and receives shaded RGB plus a transparency flag after fixed 2-cycle latency.

Parameters:
- NUM_BANKS, 8, number of palettes (one per texture); bank select width BANK_W = clog2(NUM_BANKS), min 1.
- INDEX_W, 8, palette index width; entries per bank = 2**INDEX_W.
- CHAN_W, 4, bits per colour channel; entry width = 3*CHAN_W, packed {R,G,B}, R in MSBs.
- SHADE_W, 4, distance/face shading factor width.
- TRANSP_EN, 1, enables transparency keying.
- TRANSP_INDEX, 0, index reported as transparent when TRANSP_EN=1.

Ports:
- Clk  in  1  system clock, all logic rising-edge.
- Reset_n  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse: begin filling bank load_bank.
- load_bank  in  BANK_W  target bank, sampled with load_start.
- wr_valid  in  1  palette entry valid.
- wr_data  in  3*CHAN_W  palette entry {R,G,B}.
- wr_ready  out  1  entry accepted when wr_valid&&wr_ready.
- load_busy  out  1  high while in LOAD.
- load_done  out  1  one-cycle pulse after last entry written.
- rd_valid  in  1  lookup request.
- rd_bank  in  BANK_W  bank for lookup.
- rd_index  in  INDEX_W  palette index.
- rd_shade  in  SHADE_W  shade factor, max value = full brightness.
- out_valid  out  1  result valid, rd_valid delayed 2 cycles.
- out_red, out_green, out_blue  out  CHAN_W each  shaded colour.
- out_transparent  out  1  index matched TRANSP_INDEX (0 if TRANSP_EN=0).

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, write address=0, wr_ready=0, load_busy=0, load_done=0, out_valid=0, out_* colour=0, out_transparent=0, pipeline valids cleared. Palette RAM contents are not reset and are undefined until loaded.
- Load FSM, IDLE:
  - load_start -> LOAD; latch load_bank; address=0.
  - wr_valid in IDLE is ignored; wr_ready=0.
- Load FSM, LOAD:
  - wr_ready=1, load_busy=1.
  - Each accepted beat writes wr_data to [bank][address]; address += 1.
  - Beat at address 2**INDEX_W-1 -> next cycle IDLE, load_done=1 for exactly that one cycle, address back to 0.
  - load_start while in LOAD is ignored; no restart, bank unchanged.
  - Gaps (wr_valid=0) are allowed indefinitely.
- Reset mid-load: abort to IDLE, no load_done. Entries already written keep their values; remaining entries keep their old contents.
- Lookup pipeline (no backpressure, one request per cycle):
  - Cycle N: rd_* sampled.
  - Cycle N+1: synchronous RAM read; index compare and shade registered alongside.
  - Cycle N+2: registered outputs with out_valid=1.
  - Consecutive requests stream back-to-back.
- Shading, per channel: out_c = (c * (rd_shade+1)) >> SHADE_W.
  - Intermediate width CHAN_W+SHADE_W+1, unsigned, truncating.
  - rd_shade = all-ones returns c unchanged; rd_shade = 0 returns c>>SHADE_W.
- out_transparent = TRANSP_EN && rd_index==TRANSP_INDEX, independent of bank and colour. Colour is still output when transparent.
- When out_valid=0, colour outputs hold their previous values. Consumers must qualify on out_valid.
- Read/write collision on the same bank and entry in the same cycle: read returns the old entry (read-before-write). The new value is visible to requests sampled the cycle after the write.
- Lookups to a bank under load are legal and return mixed old/new entries. Lookups to other banks are unaffected.
- rd_bank >= NUM_BANKS (non-power-of-2 count): treated as bank rd_bank mod 2**BANK_W, data undefined. No error is flagged.

Test Plan:
- Load bank 3 with entry i = {i[3:0], ~i[3:0], 4'h5} at 1 beat/cycle -> wr_ready high for 256 cycles, load_done one pulse on the cycle after beat 255. Lookup bank 3 index 0x2A, shade 0xF -> 2 cycles later out_valid=1, RGB = A,5,5.
- Shading: entry {A,C,D}, shade 7 -> out 5,6,6; shade 0 -> 0,0,0; shade F -> A,C,D.
- Transparency: lookup index 0 -> out_transparent=1 with stored colour. Index 1 -> 0. With TRANSP_EN=0, index 0 -> 0.
- Same-cycle write and read of bank 2 index 0x10 (old 0x123, new 0x456) -> returns 0x123. Read on the next cycle -> 0x456.
- Reset_n low after 100 load beats into bank 1 -> load_busy=0, no load_done. Entries 0..99 hold the new data, 100..255 hold the old data. A new load_start restarts at address 0.
- Back-to-back lookups across banks 0..7 for 16 cycles, plus load_start during LOAD and wr_valid in IDLE -> outputs match the model with latency 2 every cycle. The stray load_start and wr_valid cause no state change.
